// File: rtl/wakeup_broadcaster_pkg.sv
// Shared constants for the issue-queue wakeup path: default sizes, the
// physical-register index width and the hardwired-ready register number.
package wakeup_broadcaster_pkg;

   localparam int NUM_PHYS_REGS_DFLT = 64;
   localparam int FIFO_DEPTH_DFLT    = 8;
   localparam int LOG_PHYS           = $clog2(NUM_PHYS_REGS_DFLT);
   localparam int PHYS_REG0          = 0;

endpackage : wakeup_broadcaster_pkg

// File: rtl/wakeup_broadcaster_ready_table.sv
// Physical-register ready table: one bit per register, cleared on allocation,
// set on broadcast (allocation wins), with two combinational lookup ports.
module phys_ready_table
   import wakeup_broadcaster_pkg::*;
#(
   parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DFLT,
   parameter int LOG_PHYS_W    = $clog2(NUM_PHYS_REGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc_en,
   input  logic [LOG_PHYS_W-1:0] alloc_reg,
   input  logic                  set_en,
   input  logic [LOG_PHYS_W-1:0] set_reg,
   input  logic [LOG_PHYS_W-1:0] rd0_reg,
   output logic                  rd0_ready,
   input  logic [LOG_PHYS_W-1:0] rd1_reg,
   output logic                  rd1_ready
);

   logic [NUM_PHYS_REGS-1:0] ready_q;
   logic [NUM_PHYS_REGS-1:0] ready_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PHYS_REGS; gi++) begin : g_bit
         if (gi == PHYS_REG0) begin : g_hardwired
            always_comb ready_d[gi] = 1'b1;
         end else begin : g_tracked
            // Clear is checked first so an allocation always beats a same-edge wakeup.
            always_comb begin
               ready_d[gi] = ready_q[gi];
               if (alloc_en && (alloc_reg == LOG_PHYS_W'(gi))) begin
                  ready_d[gi] = 1'b0;
               end else if (set_en && (set_reg == LOG_PHYS_W'(gi))) begin
                  ready_d[gi] = 1'b1;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q <= '1;
      end else begin
         ready_q <= ready_d;
      end
   end

   assign rd0_ready = ready_q[rd0_reg];
   assign rd1_ready = ready_q[rd1_reg];

endmodule : phys_ready_table

// File: rtl/wakeup_broadcaster.sv
// Serializes ALU and MEM writeback completions into one wakeup broadcast per
// cycle, in arrival order, and keeps the ready table consulted at dispatch.
module wakeup_broadcaster
   import wakeup_broadcaster_pkg::*;
#(
   parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DFLT,
   parameter int FIFO_DEPTH    = FIFO_DEPTH_DFLT,
   parameter int LOG_PHYS_W    = $clog2(NUM_PHYS_REGS),
   parameter int LOG_DEPTH     = $clog2(FIFO_DEPTH)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  Alloc_IN,
   input  logic [LOG_PHYS_W-1:0] AllocReg_IN,
   input  logic [LOG_PHYS_W-1:0] Src1Reg_IN,
   input  logic [LOG_PHYS_W-1:0] Src2Reg_IN,
   output logic                  Src1Ready_OUT,
   output logic                  Src2Ready_OUT,
   input  logic                  WB0Valid_IN,
   input  logic [LOG_PHYS_W-1:0] WB0Reg_IN,
   input  logic                  WB1Valid_IN,
   input  logic [LOG_PHYS_W-1:0] WB1Reg_IN,
   output logic                  WBStall_OUT,
   output logic                  ReadyUpdate_OUT,
   output logic [LOG_PHYS_W-1:0] ReadyRegister_OUT
);

   localparam int CW = LOG_DEPTH + 1;
   localparam logic [LOG_PHYS_W-1:0] REG0 = LOG_PHYS_W'(PHYS_REG0);

   logic [CW-1:0]         count_q, count_d;
   logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [LOG_PHYS_W-1:0] mem_q [FIFO_DEPTH];
   logic [LOG_PHYS_W-1:0] mem_d [FIFO_DEPTH];
   logic                  upd_q, upd_d;
   logic [LOG_PHYS_W-1:0] reg_q, reg_d;

   logic                  stall;
   logic                  acc0;
   logic                  acc1;
   logic                  fifo_nonempty;
   logic [1:0]            n_push;
   logic [LOG_PHYS_W-1:0] slot0;
   logic [LOG_PHYS_W-1:0] slot1;

   // The stall threshold leaves room for a two-push/one-pop cycle, so no overflow check is needed.
   always_comb begin
      stall         = count_q > CW'(FIFO_DEPTH - 2);
      acc0          = !stall && WB0Valid_IN && (WB0Reg_IN != REG0);
      acc1          = !stall && WB1Valid_IN && (WB1Reg_IN != REG0) &&
                      !(WB0Valid_IN && (WB1Reg_IN == WB0Reg_IN));
      fifo_nonempty = (count_q != '0);

      upd_d  = 1'b0;
      reg_d  = reg_q;
      n_push = 2'd0;
      slot0  = WB0Reg_IN;
      slot1  = WB1Reg_IN;

      if (fifo_nonempty) begin
         upd_d  = 1'b1;
         reg_d  = mem_q[rd_ptr_q];
         n_push = {1'b0, acc0} + {1'b0, acc1};
         slot0  = acc0 ? WB0Reg_IN : WB1Reg_IN;
      end else if (acc0) begin
         upd_d  = 1'b1;
         reg_d  = WB0Reg_IN;
         n_push = {1'b0, acc1};
         slot0  = WB1Reg_IN;
      end else if (acc1) begin
         upd_d  = 1'b1;
         reg_d  = WB1Reg_IN;
      end

      mem_d = mem_q;
      if (n_push != 2'd0) begin
         mem_d[wr_ptr_q] = slot0;
      end
      if (n_push == 2'd2) begin
         mem_d[wr_ptr_q + LOG_DEPTH'(1)] = slot1;
      end

      wr_ptr_d = wr_ptr_q + LOG_DEPTH'(n_push);
      rd_ptr_d = rd_ptr_q + LOG_DEPTH'(fifo_nonempty);
      count_d  = count_q + CW'(n_push) - CW'(fifo_nonempty);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         upd_q    <= 1'b0;
         reg_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         upd_q    <= upd_d;
         reg_q    <= reg_d;
         mem_q    <= mem_d;
      end
   end

   // The table bit is set on the very edge that raises the broadcast.
   phys_ready_table #(
      .NUM_PHYS_REGS (NUM_PHYS_REGS),
      .LOG_PHYS_W    (LOG_PHYS_W)
   ) u_ready_table (
      .clk       (CLK),
      .rst_n     (RESET),
      .alloc_en  (Alloc_IN),
      .alloc_reg (AllocReg_IN),
      .set_en    (upd_d),
      .set_reg   (reg_d),
      .rd0_reg   (Src1Reg_IN),
      .rd0_ready (Src1Ready_OUT),
      .rd1_reg   (Src2Reg_IN),
      .rd1_ready (Src2Ready_OUT)
   );

   assign WBStall_OUT       = stall;
   assign ReadyUpdate_OUT   = upd_q;
   assign ReadyRegister_OUT = reg_q;

endmodule : wakeup_broadcaster

// File: tb/tb_wakeup_broadcaster.sv
// Bench for wakeup_broadcaster: directed scenarios plus random traffic, all
// checked against an ordered-queue model of the pending wakeups.
module tb_wakeup_broadcaster;

   localparam int NREG  = 64;
   localparam int DEPTH = 8;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       Alloc_IN;
   logic [5:0] AllocReg_IN, Src1Reg_IN, Src2Reg_IN;
   logic       Src1Ready_OUT, Src2Ready_OUT;
   logic       WB0Valid_IN, WB1Valid_IN;
   logic [5:0] WB0Reg_IN, WB1Reg_IN;
   logic       WBStall_OUT, ReadyUpdate_OUT;
   logic [5:0] ReadyRegister_OUT;

   wakeup_broadcaster #(.NUM_PHYS_REGS(NREG), .FIFO_DEPTH(DEPTH)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .Alloc_IN          (Alloc_IN),
      .AllocReg_IN       (AllocReg_IN),
      .Src1Reg_IN        (Src1Reg_IN),
      .Src2Reg_IN        (Src2Reg_IN),
      .Src1Ready_OUT     (Src1Ready_OUT),
      .Src2Ready_OUT     (Src2Ready_OUT),
      .WB0Valid_IN       (WB0Valid_IN),
      .WB0Reg_IN         (WB0Reg_IN),
      .WB1Valid_IN       (WB1Valid_IN),
      .WB1Reg_IN         (WB1Reg_IN),
      .WBStall_OUT       (WBStall_OUT),
      .ReadyUpdate_OUT   (ReadyUpdate_OUT),
      .ReadyRegister_OUT (ReadyRegister_OUT)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: every pending wakeup in one arrival-ordered queue.
   int q[$];
   bit tbl[NREG];
   bit exp_upd;
   int exp_reg;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < NREG; i++) tbl[i] = 1'b1;
      exp_upd = 1'b0;
      exp_reg = 0;
   endtask

   // One clock cycle of traffic, entered and left at a negative edge.
   task automatic cycle(input int a, input int ar, input int s1, input int s2,
                        input int v0, input int r0, input int v1, input int r1);
      bit stall;
      Alloc_IN    = a[0];
      AllocReg_IN = 6'(ar);
      Src1Reg_IN  = 6'(s1);
      Src2Reg_IN  = 6'(s2);
      WB0Valid_IN = v0[0];
      WB0Reg_IN   = 6'(r0);
      WB1Valid_IN = v1[0];
      WB1Reg_IN   = 6'(r1);
      #1;
      stall = (q.size() > DEPTH - 2);
      check_eq("src1_ready", int'(Src1Ready_OUT), int'(tbl[s1]));
      check_eq("src2_ready", int'(Src2Ready_OUT), int'(tbl[s2]));
      check_eq("wb_stall", int'(WBStall_OUT), int'(stall));
      @(posedge CLK);
      if (!stall) begin
         if (v0 != 0 && r0 != 0) q.push_back(r0);
         if (v1 != 0 && r1 != 0 && !(v0 != 0 && r1 == r0)) q.push_back(r1);
      end
      if (q.size() > 0) begin
         exp_upd = 1'b1;
         exp_reg = q.pop_front();
         tbl[exp_reg] = 1'b1;
      end else begin
         exp_upd = 1'b0;
      end
      if (a != 0 && ar != 0) tbl[ar] = 1'b0;
      @(negedge CLK);
      check_eq("ready_update", int'(ReadyUpdate_OUT), int'(exp_upd));
      check_eq("ready_register", int'(ReadyRegister_OUT), exp_reg);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      RESET = 1'b0;
      Alloc_IN = 0; AllocReg_IN = 0; Src1Reg_IN = 0; Src2Reg_IN = 0;
      WB0Valid_IN = 0; WB0Reg_IN = 0; WB1Valid_IN = 0; WB1Reg_IN = 0;
      model_reset();
      repeat (3) @(negedge CLK);
      check_eq("rst_update", int'(ReadyUpdate_OUT), 0);
      check_eq("rst_register", int'(ReadyRegister_OUT), 0);
      check_eq("rst_stall", int'(WBStall_OUT), 0);
      RESET = 1'b1;

      // Whole table reads ready after reset.
      for (int r = 0; r < NREG; r++) cycle(0, 0, r, NREG - 1 - r, 0, 0, 0, 0);

      // Alloc then wakeup of reg 5.
      cycle(1, 5, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 5, 5, 0, 0, 0, 0);
      cycle(0, 0, 5, 5, 1, 5, 0, 0);
      cycle(0, 0, 5, 5, 0, 0, 0, 0);

      // Two writebacks into an empty FIFO.
      cycle(0, 0, 7, 9, 1, 7, 1, 9);
      idle(3);

      // Fill to stall, keep offering while stalled, then drain.
      for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 1, 21 + 2 * i, 1, 22 + 2 * i);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 40 + i, 1, 50 + i);
      idle(12);

      // Alloc beats a same-edge wakeup; duplicate and reg-0 writebacks.
      cycle(1, 12, 12, 12, 1, 12, 0, 0);
      cycle(0, 0, 12, 12, 0, 0, 0, 0);
      cycle(0, 0, 20, 0, 1, 20, 1, 20);
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      idle(2);

      // Asynchronous reset with four pending wakeups.
      for (int i = 0; i < 4; i++) cycle(1, 30 + i, 0, 0, 1, 33 + 2 * i, 1, 34 + 2 * i);
      #2 RESET = 1'b0;
      #1;
      check_eq("async_rst_update", int'(ReadyUpdate_OUT), 0);
      check_eq("async_rst_stall", int'(WBStall_OUT), 0);
      model_reset();
      @(negedge CLK);
      RESET = 1'b1;
      for (int r = 0; r < NREG; r += 2) cycle(0, 0, r, r + 1, 0, 0, 0, 0);

      // Random traffic; a small register pool forces collisions and duplicates.
      for (int i = 0; i < 1500; i++) begin
         int pool;
         pool = ($urandom_range(0, 3) == 0) ? 63 : 15;
         cycle(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, pool),
               $urandom_range(0, pool), $urandom_range(0, 63),
               ($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, pool),
               ($urandom_range(0, 2) != 0) ? 1 : 0, $urandom_range(0, pool));
         if ($urandom_range(0, 99) == 0) idle(10);
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_wakeup_broadcaster
